// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package addsub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/cla_slice.sv
// 4-bit carry-lookahead slice; exports group propagate/generate so slices can be chained by lookahead.
module cla_slice
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               grp_p,
    output logic               grp_g
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c[4]  = grp_g | (grp_p & cin);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES register segments of CLA slices,
// with a global-stall valid/ready stream on both sides.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG = WIDTH / STAGES;
    localparam int NSL = SEG / SLICE_W;
    localparam int LST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH / SLICE_W || (WIDTH % (SLICE_W * STAGES)) != 0) begin : g_param_check
        $error("pipe_addsub: WIDTH=%0d must be a multiple of 4*STAGES, STAGES=%0d", WIDTH, STAGES);
    end

    // Handshake: a beat moves on an edge where valid && ready. The whole pipe advances together
    // whenever the output register is empty or being drained, so in_ready is exactly that condition.
    op_t              op;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             adv;
    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    flags_t           flags_q;
    flags_t           fin_flags;
    logic [WIDTH-1:0] fin_sum;

    assign op       = in_sub ? OP_SUB : OP_ADD;
    assign b_eff    = (op == OP_SUB) ? ~in_b : in_b;
    assign c0       = (op == OP_SUB) ? ~in_cin : in_cin;
    assign adv      = !valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic             v_i;
        logic [WIDTH-1:0] s_n;
        logic             c_n;
        logic [SEG-1:0]   seg_sum;
        logic [NSL:0]     cc;
        logic [NSL-1:0]   gp;
        logic [NSL-1:0]   gg;
        logic [NSL-1:0]   slice_cout;
        logic             unused_bits;

        if (k == 0) begin : g_src
            assign a_i = in_a;
            assign b_i = b_eff;
            assign s_i = '0;
            assign c_i = c0;
            assign v_i = in_valid;
        end else begin : g_src
            // Data follows only valid beats so bubbles leave the registers untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_i <= 1'b0;
                    a_i <= '0;
                    b_i <= '0;
                    s_i <= '0;
                    c_i <= 1'b0;
                end else if (adv) begin
                    v_i <= g_stage[k-1].v_i;
                    if (g_stage[k-1].v_i) begin
                        a_i <= g_stage[k-1].a_i;
                        b_i <= g_stage[k-1].b_i;
                        s_i <= g_stage[k-1].s_n;
                        c_i <= g_stage[k-1].c_n;
                    end
                end
            end
        end

        assign cc[0] = c_i;
        for (genvar j = 0; j < NSL; j++) begin : g_slice
            cla_slice u_cla (
                .a     (a_i[k*SEG + j*SLICE_W +: SLICE_W]),
                .b     (b_i[k*SEG + j*SLICE_W +: SLICE_W]),
                .cin   (cc[j]),
                .sum   (seg_sum[j*SLICE_W +: SLICE_W]),
                .cout  (slice_cout[j]),
                .grp_p (gp[j]),
                .grp_g (gg[j])
            );
            assign cc[j+1] = gg[j] | (gp[j] & cc[j]);
        end

        assign c_n = cc[NSL];

        always_comb begin
            s_n = s_i;
            s_n[k*SEG +: SEG] = seg_sum;
        end

        // Operand bits below this segment are dead; the slice carries duplicate the lookahead chain.
        assign unused_bits = ^{a_i, b_i, slice_cout};
    end

    assign fin_sum = g_stage[LST].s_n;

    always_comb begin
        fin_flags      = '0;
        fin_flags.cout = g_stage[LST].c_n;
        fin_flags.ovf  = (g_stage[LST].a_i[WIDTH-1] == g_stage[LST].b_i[WIDTH-1]) &&
                         (fin_sum[WIDTH-1] != g_stage[LST].a_i[WIDTH-1]);
        fin_flags.zero = (fin_sum == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            flags_q <= '0;
        end else if (adv) begin
            valid_q <= g_stage[LST].v_i;
            if (g_stage[LST].v_i) begin
                sum_q   <= fin_sum;
                flags_q <= fin_flags;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = flags_q.cout;
    assign out_ovf   = flags_q.ovf;
    assign out_zero  = flags_q.zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vector table and stall/reset sequences on a 32x2 instance,
// plus random streams on 8x1, 32x4 and 64x2 instances against an arithmetic reference model.
module tb_pipe_addsub;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sw_rst_n = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {cout, ovf, zero, sum} computed from integer arithmetic on w-bit operands.
    function automatic logic [66:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                              input logic sub, input logic cin);
        logic [66:0]        ua, ub, uc, ur, modv;
        logic signed [66:0] sa, sb, sc, sr, lim;
        logic [63:0]        s;
        logic               cout, ovf;
        modv = 67'd1 << w;
        ua   = {3'b0, a} % modv;
        ub   = {3'b0, b} % modv;
        uc   = {66'b0, cin};
        sa   = $signed(ua);
        sb   = $signed(ub);
        sc   = $signed(uc);
        if (ua >= (modv >> 1)) sa = sa - $signed(modv);
        if (ub >= (modv >> 1)) sb = sb - $signed(modv);
        if (sub) begin
            ur   = (ua - ub - uc) % modv;
            cout = (ua >= ub + uc);
            sr   = sa - sb - sc;
        end else begin
            ur   = ua + ub + uc;
            cout = (ur >= modv);
            ur   = ur % modv;
            sr   = sa + sb + sc;
        end
        lim = $signed(modv >> 1);
        ovf = (sr >= lim) || (sr < -lim);
        s   = ur[63:0];
        return {cout, ovf, (s == 64'd0), s};
    endfunction

    // ---------------- main 32x2 instance ----------------
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [31:0] m_in_a = '0;
    logic [31:0] m_in_b = '0;
    logic        m_in_sub = 1'b0;
    logic        m_in_cin = 1'b0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [31:0] m_out_sum;
    logic        m_out_cout, m_out_ovf, m_out_zero;

    pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_a      (m_in_a),
        .in_b      (m_in_b),
        .in_sub    (m_in_sub),
        .in_cin    (m_in_cin),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_sum   (m_out_sum),
        .out_cout  (m_out_cout),
        .out_ovf   (m_out_ovf),
        .out_zero  (m_out_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        string       name;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        m_in_a      = v.a;
        m_in_b      = v.b;
        m_in_sub    = v.sub;
        m_in_cin    = v.cin;
        #1;
        check({v.name, "_in_ready"}, m_in_ready, 1);
        @(negedge clk);
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, "_latency"}, lat, 2);
        check({v.name, "_sum"}, m_out_sum, v.sum);
        check({v.name, "_flags"}, {m_out_cout, m_out_ovf, m_out_zero}, {v.cout, v.ovf, v.zero});
    endtask

    task automatic stall_test();
        logic [66:0] exp_q[$];
        logic [31:0] sa[8];
        logic [31:0] sb[8];
        logic        ss[8];
        logic        sc[8];
        int          sent = 0;
        int          got  = 0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom();
            sb[i] = $urandom();
            ss[i] = 1'($urandom_range(1));
            sc[i] = 1'($urandom_range(1));
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            m_out_ready = !(c >= 4 && c <= 6);
            m_in_valid  = (sent < 8);
            if (sent < 8) begin
                m_in_a   = sa[sent];
                m_in_b   = sb[sent];
                m_in_sub = ss[sent];
                m_in_cin = sc[sent];
            end
            #1;
            check($sformatf("stall_in_ready_c%0d", c), m_in_ready, (c >= 4 && c <= 6) ? 0 : 1);
            if (c >= 4 && c <= 6) check($sformatf("stall_out_valid_c%0d", c), m_out_valid, 1);
            if (m_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stall_spurious_beat", m_out_valid, 0);
                end else begin
                    check($sformatf("stall_data_c%0d", c),
                          {m_out_cout, m_out_ovf, m_out_zero, 32'd0, m_out_sum}, exp_q[0]);
                    if (m_out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (m_in_valid && m_in_ready) begin
                exp_q.push_back(ref_model(32, {32'd0, m_in_a}, {32'd0, m_in_b}, m_in_sub, m_in_cin));
                sent++;
            end
        end
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        check("stall_beats_out", got, 8);
    endtask

    task automatic reset_test();
        @(negedge clk);
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        m_in_a      = $urandom();
        m_in_b      = $urandom();
        @(negedge clk);
        m_in_a = $urandom();
        @(negedge clk);
        m_in_valid = 1'b0;
        #1;
        check("rst_beat_in_flight", m_out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", m_out_valid, 0);
        check("rst_async_data", {m_out_sum, m_out_cout, m_out_ovf, m_out_zero}, 0);
        check("rst_in_ready", m_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_no_stale_c%0d", c), m_out_valid, 0);
        end
    endtask

    // ---------------- random sweep instances ----------------
    localparam int NSW       = 3;
    localparam int SW_BEATS  = 10000;
    localparam int SW_W[NSW] = '{8, 32, 64};
    localparam int SW_S[NSW] = '{1, 4, 2};

    for (genvar g = 0; g < NSW; g++) begin : g_sweep
        localparam int W = SW_W[g];
        localparam int S = SW_S[g];
        logic         iv = 1'b0;
        logic         ir;
        logic [W-1:0] ia = '0;
        logic [W-1:0] ib = '0;
        logic         isub = 1'b0;
        logic         icin = 1'b0;
        logic         ov;
        logic         ordy = 1'b1;
        logic [W-1:0] os;
        logic         oc, oo, oz;
        logic         done = 1'b0;
        logic [66:0]  exp_q[$];

        pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (ia),
            .in_b      (ib),
            .in_sub    (isub),
            .in_cin    (icin),
            .out_valid (ov),
            .out_ready (ordy),
            .out_sum   (os),
            .out_cout  (oc),
            .out_ovf   (oo),
            .out_zero  (oz)
        );

        function automatic logic [W-1:0] rand_op();
            case ($urandom_range(7))
                0:       return '1;
                1:       return '0;
                default: return W'({$urandom(), $urandom()});
            endcase
        endfunction

        task automatic take_output(input string tag);
            if (ov && ordy) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious"}, ov, 0);
                end else begin
                    check(tag, {oc, oo, oz, 64'(os)}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        endtask

        initial begin
            int sent = 0;
            int cyc  = 0;
            string tag;
            tag = $sformatf("sweep_w%0d_s%0d", W, S);
            wait (sw_rst_n === 1'b1);
            while (sent < SW_BEATS && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                iv   = ($urandom_range(3) != 0);
                ia   = rand_op();
                ib   = rand_op();
                isub = 1'($urandom_range(1));
                icin = 1'($urandom_range(1));
                ordy = ($urandom_range(3) != 0);
                #1;
                take_output(tag);
                if (iv && ir) begin
                    exp_q.push_back(ref_model(W, 64'(ia), 64'(ib), isub, icin));
                    sent++;
                end
            end
            check({tag, "_beats_in"}, sent, SW_BEATS);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                iv   = 1'b0;
                ordy = 1'b1;
                #1;
                take_output(tag);
            end
            check({tag, "_drained"}, exp_q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_wrap"};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf"};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf"};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_neg"};
        vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, "sub_borrow"};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "add_cin"};
        vecs[6] = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_zero"};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "add_negovf"};
        vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "add_segcarry"};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_borrow0"};

        #12;
        check("reset_out_valid", m_out_valid, 0);
        check("reset_out_data", {m_out_sum, m_out_cout, m_out_ovf, m_out_zero}, 0);
        check("reset_in_ready", m_in_ready, 1);
        @(negedge clk);
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);
        stall_test();
        reset_test();
        run_vec(vecs[0]);

        c = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && c < 80000) begin
            @(negedge clk);
            c++;
        end
        check("sweep_complete", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
